// File: rtl/emboss_pkg.sv
// Shared definitions for the streaming 3x3 filter: mode codes, kernel
// coefficients and the accumulator sizing rule.
package emboss_pkg;

    localparam logic [1:0] MODE_EMBOSS  = 2'd0;
    localparam logic [1:0] MODE_SHARPEN = 2'd1;
    localparam logic [1:0] MODE_EDGE    = 2'd2;
    localparam logic [1:0] MODE_BLUR    = 2'd3;

    localparam int COEF_W = 5;
    typedef logic signed [COEF_W-1:0] coef_t;

    // Row-major, top-left first; indexed by the mode code.
    localparam coef_t KERNELS [4][9] = '{
        '{-5'sd2, -5'sd1,  5'sd0, -5'sd1,  5'sd1,  5'sd1,  5'sd0,  5'sd1,  5'sd2},
        '{ 5'sd0, -5'sd1,  5'sd0, -5'sd1,  5'sd5, -5'sd1,  5'sd0, -5'sd1,  5'sd0},
        '{-5'sd1, -5'sd1, -5'sd1, -5'sd1,  5'sd8, -5'sd1, -5'sd1, -5'sd1, -5'sd1},
        '{ 5'sd1,  5'sd2,  5'sd1,  5'sd2,  5'sd4,  5'sd2,  5'sd1,  5'sd2,  5'sd1}
    };

    function automatic int acc_width(input int pix_w);
        return pix_w + 6;
    endfunction

endpackage

// File: rtl/emboss_mac3x3.sv
// Combinational 3x3 multiply-accumulate with per-mode bias/shift and
// clamping to the unsigned pixel range.
module emboss_mac3x3
    import emboss_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [8:0][PIX_W-1:0] win,
    input  logic [1:0]            mode,
    output logic [PIX_W-1:0]      pix
);

    localparam int AW = acc_width(PIX_W);
    localparam logic signed [AW-1:0] BIAS    = AW'(2 ** (PIX_W - 1));
    localparam logic signed [AW-1:0] PIX_MAX = AW'(2 ** PIX_W - 1);

    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] acc;

    always_comb begin
        sum = '0;
        for (int k = 0; k < 9; k++) begin
            sum = sum + AW'(KERNELS[mode][k]) * $signed({{(AW-PIX_W){1'b0}}, win[k]});
        end

        case (mode)
            MODE_EMBOSS: acc = sum + BIAS;
            MODE_BLUR:   acc = sum >>> 4;
            default:     acc = sum;
        endcase

        if (acc < 0) begin
            pix = '0;
        end else if (acc > PIX_MAX) begin
            pix = '1;
        end else begin
            pix = acc[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/emboss_stream.sv
// Streaming valid-mode 3x3 filter: two line buffers build the window from a
// raster pixel stream; one output register carries valid/ready backpressure.
module emboss_stream
    import emboss_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_last,
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [1:0]       frame_mode;
    logic             run;
    logic             accept;
    logic             completes;
    logic             last_in_frame;
    logic [PIX_W-1:0] top_pix;
    logic [PIX_W-1:0] mid_pix;
    logic [PIX_W-1:0] mac_pix;
    logic [8:0][PIX_W-1:0] win;

    logic [PIX_W-1:0] lb_top [IMG_W];
    logic [PIX_W-1:0] lb_mid [IMG_W];
    // Per window row: [0] holds column c-2, [1] holds column c-1.
    logic [PIX_W-1:0] win_reg [3][2];

    assign s_ready       = run && (!m_valid || m_ready);
    assign accept        = s_valid && s_ready;
    assign top_pix       = lb_top[col];
    assign mid_pix       = lb_mid[col];
    assign completes     = (row >= RW'(2)) && (col >= CW'(2));
    assign last_in_frame = (row == ROW_LAST) && (col == COL_LAST);

    assign win = {s_data,  win_reg[2][1], win_reg[2][0],
                  mid_pix, win_reg[1][1], win_reg[1][0],
                  top_pix, win_reg[0][1], win_reg[0][0]};

    emboss_mac3x3 #(.PIX_W(PIX_W)) u_mac (
        .win  (win),
        .mode (frame_mode),
        .pix  (mac_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= 1'b0;
            col        <= '0;
            row        <= '0;
            frame_mode <= MODE_EMBOSS;
        end else begin
            run <= 1'b1;
            if (accept) begin
                if (col == '0 && row == '0) begin
                    frame_mode <= mode;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Line buffers and window columns carry no reset; stale contents are
    // always overwritten before a new frame's first window completes.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top[col]   <= lb_mid[col];
            lb_mid[col]   <= s_data;
            win_reg[0][0] <= win_reg[0][1];
            win_reg[0][1] <= top_pix;
            win_reg[1][0] <= win_reg[1][1];
            win_reg[1][1] <= mid_pix;
            win_reg[2][0] <= win_reg[2][1];
            win_reg[2][1] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= m_valid && m_ready && m_last;
            if (accept && completes) begin
                m_valid <= 1'b1;
                m_data  <= mac_pix;
                m_last  <= last_in_frame;
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_emboss_stream.sv
// Randomized self-checking bench for emboss_stream against a direct
// convolution reference model over whole frames.
module tb_emboss_stream;

    localparam int PIX_W = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [PIX_W-1:0] s_data = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [PIX_W-1:0] m_data;
    logic             m_last;
    logic             frame_done;

    int checks = 0;
    int failures = 0;
    int frames_expected = 0;
    int frames_seen = 0;

    int pix [IMG_H][IMG_W];
    int ker [4][3][3] = '{
        '{'{-2, -1, 0}, '{-1, 1, 1}, '{0, 1, 2}},
        '{'{0, -1, 0}, '{-1, 5, -1}, '{0, -1, 0}},
        '{'{-1, -1, -1}, '{-1, 8, -1}, '{-1, -1, -1}},
        '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}}
    };

    typedef struct {
        logic [PIX_W-1:0] data;
        logic [1:0]       mode;
    } beat_t;

    typedef struct {
        logic [PIX_W-1:0] data;
        logic             last;
    } exp_t;

    beat_t in_q[$];
    exp_t  exp_q[$];

    emboss_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // kind: 0 flat, 1 single pixel at (3,3), 2 single pixel at (0,0), 3 ramp, 4 random
    task automatic fillFrame(input int kind, input int value);
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                case (kind)
                    0: pix[r][c] = value;
                    1: pix[r][c] = (r == 3 && c == 3) ? value : 0;
                    2: pix[r][c] = (r == 0 && c == 0) ? value : 0;
                    3: pix[r][c] = (c + r * IMG_W) % (1 << PIX_W);
                    default: pix[r][c] = int'($urandom_range((1 << PIX_W) - 1));
                endcase
            end
        end
    endtask

    // Queue the frame's input beats (mode is only meaningful on the first
    // beat, so later beats carry junk) and its expected filtered outputs.
    task automatic queueFrame(input logic [1:0] fmode);
        int acc;
        beat_t b;
        exp_t e;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                b.data = PIX_W'(pix[r][c]);
                b.mode = (r == 0 && c == 0) ? fmode : 2'($urandom);
                in_q.push_back(b);
            end
        end
        for (int r = 1; r < IMG_H - 1; r++) begin
            for (int c = 1; c < IMG_W - 1; c++) begin
                acc = 0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        acc += ker[fmode][i][j] * pix[r - 1 + i][c - 1 + j];
                    end
                end
                if (fmode == 2'd0) acc += 1 << (PIX_W - 1);
                if (fmode == 2'd3) acc = acc >>> 4;
                if (acc < 0) acc = 0;
                if (acc > (1 << PIX_W) - 1) acc = (1 << PIX_W) - 1;
                e.data = PIX_W'(acc);
                e.last = (r == IMG_H - 2) && (c == IMG_W - 2);
                exp_q.push_back(e);
            end
        end
        frames_expected++;
    endtask

    // Drive queued beats with random gaps/backpressure; inputs change on the
    // falling edge and everything is sampled 2ns later, before the next rise.
    task automatic applyStimulus(input int valid_pct, input int ready_pct);
        int cycles = 0;
        int budget = 200 + 20 * in_q.size();
        logic stalled = 1'b0;
        logic prev_last_acc = 1'b0;
        logic [PIX_W-1:0] held_data = '0;
        logic held_last = 1'b0;
        exp_t e;
        while ((in_q.size() > 0 || exp_q.size() > 0) && cycles < budget) begin
            @(negedge clk);
            s_valid = (in_q.size() > 0) && ($urandom_range(99) < valid_pct);
            if (s_valid) begin
                s_data = in_q[0].data;
                mode   = in_q[0].mode;
            end else begin
                s_data = PIX_W'($urandom);
                mode   = 2'($urandom);
            end
            m_ready = ($urandom_range(99) < ready_pct);
            #2;
            checkOutput("frame_done", frame_done, prev_last_acc);
            if (frame_done) frames_seen++;
            checkOutput("s_ready", s_ready, !m_valid || m_ready);
            if (stalled) begin
                checkOutput("stall_valid", m_valid, 1);
                checkOutput("stall_data", m_data, held_data);
                checkOutput("stall_last", m_last, held_last);
            end
            prev_last_acc = 1'b0;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("m_data", m_data, e.data);
                    checkOutput("m_last", m_last, e.last);
                end
                prev_last_acc = m_last;
            end
            stalled   = m_valid && !m_ready;
            held_data = m_data;
            held_last = m_last;
            if (s_valid && s_ready) void'(in_q.pop_front());
            cycles++;
        end
        if (cycles >= budget) begin
            checkOutput("timeout", cycles, 0);
            in_q.delete();
            exp_q.delete();
        end
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b1;
        #2;
        checkOutput("frame_done_tail", frame_done, prev_last_acc);
        if (frame_done) frames_seen++;
        checkOutput("idle_valid", m_valid, 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_s_ready"}, s_ready, 0);
        checkOutput({tag, "_m_valid"}, m_valid, 0);
        checkOutput({tag, "_m_data"}, m_data, 0);
        checkOutput({tag, "_m_last"}, m_last, 0);
        checkOutput({tag, "_frame_done"}, frame_done, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("s_ready_at_release", s_ready, 0);
        @(negedge clk);
        #2;
        checkOutput("s_ready_after_release", s_ready, 1);

        $display("[TB] flat frames");
        fillFrame(0, 100);
        queueFrame(2'd0);
        applyStimulus(100, 100);
        fillFrame(0, 50);
        queueFrame(2'd1);
        fillFrame(0, 80);
        queueFrame(2'd3);
        applyStimulus(100, 100);

        $display("[TB] impulse frames");
        fillFrame(1, 255);
        queueFrame(2'd2);
        applyStimulus(100, 100);
        fillFrame(2, 255);
        queueFrame(2'd0);
        applyStimulus(100, 50);

        $display("[TB] ramp and random frames with backpressure");
        for (int m = 0; m < 4; m++) begin
            fillFrame(3, 0);
            queueFrame(2'(m));
            applyStimulus(70, 50);
        end
        for (int f = 0; f < 3; f++) begin
            fillFrame(4, 0);
            queueFrame(2'($urandom));
        end
        applyStimulus(60, 50);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = PIX_W'($urandom);
            mode    = 2'($urandom);
            m_ready = 1'b1;
        end
        @(negedge clk);
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        fillFrame(4, 0);
        queueFrame(2'($urandom));
        applyStimulus(80, 60);

        checkOutput("frame_count", frames_seen, frames_expected);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
